// File: rtl/vmicro16_apb_gpio_port_if.sv
// rtl/vmicro16_apb_gpio_port_if.sv - APB bus bundle between interconnect and the GPIO port
interface vmicro16_apb_gpio_port_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] S_PADDR;
  logic                  S_PWRITE;
  logic                  S_PSELx;
  logic                  S_PENABLE;
  logic [BUS_WIDTH-1:0]  S_PWDATA;
  logic [BUS_WIDTH-1:0]  S_PRDATA;
  logic                  S_PREADY;

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY
  );

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY
  );
endinterface

// File: rtl/vmicro16_apb_gpio_port.sv
// rtl/vmicro16_apb_gpio_port.sv - APB GPIO port: direction, synced inputs, set/clear, edge irq
module vmicro16_apb_gpio_port #(
  parameter int BUS_WIDTH  = 16,
  parameter int PINS       = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int OUT_RESET  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  vmicro16_apb_gpio_port_if.slave s_apb,
  input  logic [PINS-1:0]         gpio_in,
  output logic [PINS-1:0]         gpio_out,
  output logic [PINS-1:0]         gpio_oe,
  output logic                    irq
);
  localparam logic [ADDR_WIDTH-1:0] A_OUT   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_IN    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_DIR   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_IEN   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_ISTAT = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_SET   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_CLR   = ADDR_WIDTH'(6);

  logic                 r_pready;
  logic [BUS_WIDTH-1:0] r_prdata;
  logic [PINS-1:0]      r_out;
  logic [PINS-1:0]      r_dir;
  logic [PINS-1:0]      r_ien;
  logic [PINS-1:0]      r_istat;
  logic [PINS-1:0]      r_s1;
  logic [PINS-1:0]      r_s2;
  logic [PINS-1:0]      r_prev;
  logic                 r_irq;

  logic                 w_access;
  logic                 w_commit;
  logic                 w_rd_strobe;
  logic [PINS-1:0]      w_wdata;
  logic [PINS-1:0]      w_in;
  logic [PINS-1:0]      w_rise;
  logic [PINS-1:0]      w_istat_clr;
  logic [BUS_WIDTH-1:0] w_rdata;

  // PREADY rises after the first access cycle, so every transfer sees one wait state.
  assign w_access    = s_apb.S_PSELx & s_apb.S_PENABLE;
  assign w_commit    = w_access & r_pready & s_apb.S_PWRITE;
  assign w_rd_strobe = w_access & ~r_pready & ~s_apb.S_PWRITE;
  assign w_wdata     = s_apb.S_PWDATA[PINS-1:0];

  assign w_in        = r_s2 & ~r_dir;
  assign w_rise      = r_s2 & ~r_prev & ~r_dir;
  assign w_istat_clr = (w_commit && s_apb.S_PADDR == A_ISTAT) ? w_wdata : '0;

  always_comb begin
    w_rdata = '0;
    case (s_apb.S_PADDR)
      A_OUT:   w_rdata[PINS-1:0] = r_out;
      A_IN:    w_rdata[PINS-1:0] = w_in;
      A_DIR:   w_rdata[PINS-1:0] = r_dir;
      A_IEN:   w_rdata[PINS-1:0] = r_ien;
      A_ISTAT: w_rdata[PINS-1:0] = r_istat;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pready <= 1'b0;
      r_prdata <= '0;
      r_out    <= OUT_RESET[PINS-1:0];
      r_dir    <= '0;
      r_ien    <= '0;
      r_istat  <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_prev   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_pready <= w_access & ~r_pready;
      r_prdata <= w_rd_strobe ? w_rdata : '0;
      r_s1     <= gpio_in;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      // A fresh edge on a bit being cleared wins, so no event is lost.
      r_istat  <= (r_istat & ~w_istat_clr) | w_rise;
      r_irq    <= |(r_istat & r_ien);
      if (w_commit) begin
        case (s_apb.S_PADDR)
          A_OUT:   r_out <= w_wdata;
          A_DIR:   r_dir <= w_wdata;
          A_IEN:   r_ien <= w_wdata;
          A_SET:   r_out <= r_out | w_wdata;
          A_CLR:   r_out <= r_out & ~w_wdata;
          default: ;
        endcase
      end
    end
  end

  assign s_apb.S_PREADY = r_pready;
  assign s_apb.S_PRDATA = r_prdata;
  assign gpio_out       = r_out;
  assign gpio_oe        = r_dir;
  assign irq            = r_irq;
endmodule

// File: tb/tb_vmicro16_apb_gpio_port.sv
// tb/tb_vmicro16_apb_gpio_port.sv - vector table plus corner sequences with a read scoreboard
module tb_vmicro16_apb_gpio_port;
  logic        clk;
  logic        reset;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  int n_checks;
  int n_err;
  logic [15:0] sb[$];

  vmicro16_apb_gpio_port_if #(.BUS_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  vmicro16_apb_gpio_port #(
    .BUS_WIDTH(16), .PINS(16), .ADDR_WIDTH(3), .OUT_RESET(0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_apb    (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts at the current time (caller is just past a rising edge); returns just past the commit edge.
  task automatic xfer(input logic wr, input logic [2:0] a, input logic [15:0] d,
                      input logic [15:0] exp);
    int cnt;
    bus.S_PSELx   = 1'b1;
    bus.S_PENABLE = 1'b0;
    bus.S_PWRITE  = wr;
    bus.S_PADDR   = a;
    bus.S_PWDATA  = d;
    if (!wr) sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.S_PENABLE = 1'b1;
    chk("ready_before_wait", {15'd0, bus.S_PREADY}, 16'd0);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!bus.S_PREADY && cnt < 4);
    chk("wait_states", 16'(cnt), 16'd1);
    @(posedge clk);
    #1;
    bus.S_PENABLE = 1'b0;
  endtask

  task automatic idle();
    bus.S_PSELx   = 1'b0;
    bus.S_PENABLE = 1'b0;
    bus.S_PWRITE  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    tbl[0]  = '{1'b1, 3'd0, 16'h7008, 16'h0000, 16'h7008, 16'h0000};
    tbl[1]  = '{1'b1, 3'd2, 16'hFFFF, 16'h0000, 16'h7008, 16'hFFFF};
    tbl[2]  = '{1'b0, 3'd0, 16'h0000, 16'h7008, 16'h7008, 16'hFFFF};
    tbl[3]  = '{1'b1, 3'd0, 16'h00F0, 16'h0000, 16'h00F0, 16'hFFFF};
    tbl[4]  = '{1'b1, 3'd5, 16'h0F00, 16'h0000, 16'h0FF0, 16'hFFFF};
    tbl[5]  = '{1'b1, 3'd6, 16'h0030, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[6]  = '{1'b0, 3'd0, 16'h0000, 16'h0FC0, 16'h0FC0, 16'hFFFF};
    tbl[7]  = '{1'b0, 3'd5, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[8]  = '{1'b0, 3'd6, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[9]  = '{1'b1, 3'd5, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[10] = '{1'b1, 3'd6, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[11] = '{1'b0, 3'd7, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[12] = '{1'b1, 3'd7, 16'hFFFF, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[13] = '{1'b0, 3'd2, 16'h0000, 16'hFFFF, 16'h0FC0, 16'hFFFF};
    tbl[14] = '{1'b0, 3'd1, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[15] = '{1'b1, 3'd3, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};
    tbl[16] = '{1'b0, 3'd4, 16'h0000, 16'h0000, 16'h0FC0, 16'hFFFF};

    // Read-data monitor: pops the scoreboard on every completed read.
    fork
      forever begin
        @(negedge clk);
        if (bus.S_PSELx && bus.S_PENABLE && bus.S_PREADY && !bus.S_PWRITE) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: got %h with no read pending", bus.S_PRDATA);
          end else begin
            logic [15:0] e;
            e = sb.pop_front();
            if (bus.S_PRDATA !== e) begin
              n_err++;
              $display("FAIL rd_data: got %h expected %h", bus.S_PRDATA, e);
            end
          end
        end
      end
    join_none

    reset   = 1'b0;
    gpio_in = 16'h0000;
    idle();
    bus.S_PADDR  = 3'd0;
    bus.S_PWDATA = 16'h0000;
    wait_cycles(3);
    chk("rst_gpio_out", gpio_out, 16'h0000);
    chk("rst_gpio_oe", gpio_oe, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_pready", {15'd0, bus.S_PREADY}, 16'd0);
    chk("rst_prdata", bus.S_PRDATA, 16'h0000);
    reset = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 17; i++) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rd);
      chk($sformatf("vec%0d_out", i), gpio_out, tbl[i].exp_out);
      chk($sformatf("vec%0d_oe", i), gpio_oe, tbl[i].exp_oe);
    end
    idle();
    wait_cycles(1);

    // Asynchronous reset must clear outputs before the next clock edge.
    xfer(1'b1, 3'd0, 16'hFFFF, 16'h0);
    idle();
    chk("pre_arst_out", gpio_out, 16'hFFFF);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out", gpio_out, 16'h0000);
    chk("arst_oe", gpio_oe, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cycles(1);

    // Input synchronizer and DIR masking.
    xfer(1'b1, 3'd2, 16'h00FF, 16'h0);
    gpio_in = 16'hA5A5;
    xfer(1'b0, 3'd1, 16'h0, 16'h0000);
    xfer(1'b0, 3'd1, 16'h0, 16'hA500);
    xfer(1'b0, 3'd4, 16'h0, 16'hA500);
    chk("sync_irq_masked", {15'd0, irq}, 16'd0);
    xfer(1'b1, 3'd4, 16'hFFFF, 16'h0);
    xfer(1'b0, 3'd4, 16'h0, 16'h0000);
    idle();

    // Rising-edge interrupt and write-1-to-clear.
    gpio_in = 16'h0000;
    wait_cycles(4);
    xfer(1'b1, 3'd3, 16'h0100, 16'h0);
    idle();
    gpio_in = 16'h0100;
    wait_cycles(4);
    chk("irq_set", {15'd0, irq}, 16'd1);
    xfer(1'b0, 3'd4, 16'h0, 16'h0100);
    xfer(1'b1, 3'd4, 16'h0100, 16'h0);
    idle();
    wait_cycles(1);
    chk("irq_cleared", {15'd0, irq}, 16'd0);
    xfer(1'b0, 3'd4, 16'h0, 16'h0000);
    idle();

    // W1C landing on the same edge as a fresh rise keeps the bit.
    gpio_in = 16'h0000;
    wait_cycles(4);
    gpio_in = 16'h0100;
    wait_cycles(4);
    gpio_in = 16'h0000;
    wait_cycles(4);
    gpio_in = 16'h0100;
    xfer(1'b1, 3'd4, 16'h0100, 16'h0);
    xfer(1'b0, 3'd4, 16'h0, 16'h0100);
    idle();
    wait_cycles(1);
    chk("collide_irq", {15'd0, irq}, 16'd1);

    // Back-to-back writes with no idle cycle.
    xfer(1'b1, 3'd0, 16'h1234, 16'h0);
    xfer(1'b1, 3'd2, 16'h0F0F, 16'h0);
    idle();
    chk("b2b_out", gpio_out, 16'h1234);
    chk("b2b_oe", gpio_oe, 16'h0F0F);

    // Select dropped while PREADY is high: no write, PREADY falls.
    @(posedge clk);
    #1;
    bus.S_PSELx   = 1'b1;
    bus.S_PENABLE = 1'b0;
    bus.S_PWRITE  = 1'b1;
    bus.S_PADDR   = 3'd0;
    bus.S_PWDATA  = 16'hBEEF;
    wait_cycles(1);
    bus.S_PENABLE = 1'b1;
    wait_cycles(1);
    chk("abort_ready_high", {15'd0, bus.S_PREADY}, 16'd1);
    idle();
    wait_cycles(1);
    chk("abort_ready_low", {15'd0, bus.S_PREADY}, 16'd0);
    chk("abort_no_write", gpio_out, 16'h1234);

    wait_cycles(2);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/vmicro16_apb_gpio_port.md
Name: vmicro16_apb_gpio_port

Overview:
- APB responder GPIO peripheral. It is the block that drives the SoC `gpio1` pins which the system benches check, for example the summation result 16'h7008.
- Adds per-pin direction control, synchronized input sampling, and atomic set/clear writes.
- Adds sticky rising-edge interrupt status with a level interrupt output to the core.
- Sits on the SoC APB interconnect as one PSEL slot, clocked by the core clock.

Parameters:
- BUS_WIDTH, 16, APB data width (PWDATA/PRDATA).
- PINS, 16, number of GPIO pins; must be ≤ BUS_WIDTH. Unused upper data bits read 0.
- ADDR_WIDTH, 3, width of the word-address field decoded.
- OUT_RESET, 0, reset value of the output register.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- S_PADDR  in  ADDR_WIDTH  register word address.
- S_PWRITE  in  1  1 = write transfer.
- S_PSELx  in  1  slave select.
- S_PENABLE  in  1  APB access phase.
- S_PWDATA  in  BUS_WIDTH  write data.
- S_PRDATA  out  BUS_WIDTH  read data.
- S_PREADY  out  1  transfer complete.
- gpio_in  in  PINS  asynchronous pin inputs.
- gpio_out  out  PINS  output register value.
- gpio_oe  out  PINS  per-pin output enable (1 = drive).
- irq  out  1  level interrupt.

Behaviour:
- Register map (word addresses):
  - 0 OUT: RW.
  - 1 IN: RO, synchronized pins.
  - 2 DIR: RW, 1 = output.
  - 3 IEN: RW.
  - 4 ISTAT: read, write-1-to-clear.
  - 5 SET: WO, OUT |= data.
  - 6 CLR: WO, OUT &= ~data.
  - 7: unmapped; reads 0, writes ignored.
  - WO registers read 0.
- Reset (reset=0, asynchronous):
  - OUT=OUT_RESET, DIR=0, IEN=0, ISTAT=0.
  - Both synchronizer stages and the edge-history register = 0.
  - S_PRDATA=0, S_PREADY=0, irq=0, gpio_oe=0.
- APB timing:
  - Setup phase: PSELx=1, PENABLE=0.
  - Access phase: PSELx=1, PENABLE=1.
  - S_PREADY is registered. It asserts in the cycle after the first access-phase cycle, which gives exactly one wait state.
  - S_PREADY deasserts the cycle after it was high, so back-to-back transfers each get one wait state.
- Write commit: register writes take effect on the clock edge where PSELx & PENABLE & PREADY & PWRITE are all 1. Exactly once per transfer.
- Read data: S_PRDATA is registered and valid while S_PREADY=1. It returns the register value sampled at the edge that raises PREADY. At all other times S_PRDATA is 0.
- Outputs: gpio_out=OUT and gpio_oe=DIR, both registered and visible the cycle after the write commits.
- Input path:
  - gpio_in passes through a 2-flop synchronizer (s1→s2). IN = s2 & ~DIR; output pins read 0 in IN.
  - Pin-to-IN latency is 2 clk.
- Edge detect:
  - prev<=s2 every cycle.
  - rise = s2 & ~prev & ~DIR.
  - ISTAT |= rise each cycle.
- W1C collision: if a W1C of ISTAT and a new rise on the same bit coincide, the bit ends at 1 (new edge wins).
- irq is registered: irq <= |(ISTAT & IEN). Changes to IEN take effect one cycle after commit.
- SET/CLR collision: SET/CLR with data 0 leaves OUT unchanged. SET and CLR never coincide, since there is one transfer at a time.
- Aborted transfers: if PSELx drops mid-transfer (protocol violation), PREADY returns to 0 the next cycle and no write occurs.
- Reset mid-transfer: all state is cleared immediately and the transfer is lost. The master must restart the transfer.
- Data width: write bits above PINS are ignored; read bits above PINS = 0.

Test Plan:
- Reset then idle:
  - Required: gpio_out=0, gpio_oe=0, irq=0, S_PREADY=0.
  - Then assert reset low asynchronously while OUT=16'hFFFF → gpio_out=0 before the next clk edge.
- Write then read:
  - Write OUT=16'h7008 and DIR=16'hFFFF → gpio_out=16'h7008 and gpio_oe=16'hFFFF one cycle after commit.
  - Read OUT → 16'h7008, with PREADY high exactly one cycle after PENABLE rises.
- Atomic set/clear: OUT=16'h00F0; SET 16'h0F00; CLR 16'h0030 → gpio_out=16'h0FC0. A read of SET returns 0.
- Input sync and DIR masking:
  - DIR=16'h00FF, gpio_in=16'hA5A5 → IN reads 16'hA500 no earlier than 2 clk after the pin change.
- Interrupts:
  - IEN=16'h0100; raise gpio_in[8] 0→1 → ISTAT=16'h0100, irq=1.
  - W1C 16'h0100 → ISTAT=0, irq=0 one cycle later.
  - A rising edge in the same cycle as the W1C leaves ISTAT=16'h0100.
- Unmapped and back-to-back:
  - Read addr 7 → 0; write addr 7 changes nothing.
  - Two consecutive writes with no idle cycle → both commit, each with one wait state.
